// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter that shares one spi_master among NREQ command sources, one transfer per grant.
// Optional build macro SPI_ARB_PRIO0_EN gives requester 0 absolute priority over the round robin.
module spi_req_arbiter #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    output logic [NREQ-1:0]               req_ready,
    input  logic [NREQ*2-1:0]             req_ss,
    input  logic [NREQ*DWIDTH-1:0]        req_data,
    input  logic [NREQ*AWIDTH-1:0]        req_addr,
    input  logic [NREQ*2-1:0]             req_size,
    input  logic [NREQ-1:0]               req_write,
    input  logic [NREQ*2-1:0]             req_mode,
    output logic [NREQ-1:0]               req_done,
    output logic [NREQ-1:0]               req_err,
    output logic                          master_en,
    output logic [DWIDTH+AWIDTH+4:0]      driver_data,
    output logic [1:0]                    driver_cfg,
    input  logic                          driver_read,
    input  logic [3:0]                    ss_n,
    output logic                          busy,
    output logic [$clog2(NREQ)-1:0]       grant_id,
    output logic [1:0]                    fsm_state
);
    localparam int PW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_BUSY  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Handshake: a requester holds req_valid and payload until its req_ready pulse;
    // req_ready is asserted combinationally in IDLE for the winner only, and the
    // payload is captured on that same clock edge.
    logic [1:0]        state;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     win;
    logic [PW-1:0]     next_ptr;
    logic              win_found;
    logic              accept;
    logic [NREQ-1:0]   win_oh;
    logic [1:0]        w_ss;
    logic [DWIDTH-1:0] w_data;
    logic [AWIDTH-1:0] w_addr;
    logic [1:0]        w_size;
    logic              w_write;
    logic [1:0]        w_mode;

    // Lowest valid index overall is the wrap candidate; lowest valid at/after rr_ptr overrides it.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                win       = PW'(i);
                win_found = 1'b1;
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (PW'(i) >= rr_ptr)) begin
                win = PW'(i);
            end
        end
`ifdef SPI_ARB_PRIO0_EN
        if (req_valid[0]) begin
            win = '0;
        end
`endif
    end

    always_comb begin
        w_ss    = '0;
        w_data  = '0;
        w_addr  = '0;
        w_size  = '0;
        w_write = 1'b0;
        w_mode  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == PW'(i)) begin
                w_ss    = req_ss[2*i +: 2];
                w_data  = req_data[DWIDTH*i +: DWIDTH];
                w_addr  = req_addr[AWIDTH*i +: AWIDTH];
                w_size  = req_size[2*i +: 2];
                w_write = req_write[i];
                w_mode  = req_mode[2*i +: 2];
            end
        end
    end

    assign next_ptr  = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
    assign accept    = (state == S_IDLE) && win_found && !rst;
    assign win_oh    = {{(NREQ-1){1'b0}}, 1'b1} << win;
    assign req_ready = accept ? win_oh : '0;
    assign req_done  = (state == S_DONE) ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_id) : '0;
    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    // Low as soon as the master is back in LOAD, so it parks instead of re-reading driver_data.
    always_comb begin
        master_en = 1'b0;
        if (state == S_ISSUE) begin
            master_en = 1'b1;
        end else if (state == S_BUSY) begin
            master_en = (ss_n != 4'hF);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            driver_data <= '0;
            driver_cfg  <= '0;
            req_err     <= '0;
        end else begin
            req_err <= '0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        grant_id <= win;
`ifdef SPI_ARB_PRIO0_EN
                        if (!req_valid[0]) begin
                            rr_ptr <= next_ptr;
                        end
`else
                        rr_ptr <= next_ptr;
`endif
                        if (w_size == 2'd3) begin
                            req_err <= win_oh;
                        end else begin
                            driver_data <= {w_ss, w_data, w_addr, w_size, w_write};
                            driver_cfg  <= w_mode;
                            state       <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (driver_read) begin
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (ss_n == 4'hF) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_req_arbiter.sv
// Directed bench for spi_req_arbiter: vector table of single grants plus hand-written
// sequences for held requests, ISSUE stall and mid-transfer reset.
module tb_spi_req_arbiter;
    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int AW   = 8;
    localparam int DDW  = DW + AW + 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*2-1:0] req_ss = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ*AW-1:0] req_addr = '0;
    logic [NREQ*2-1:0] req_size = '0;
    logic [NREQ-1:0]   req_write = '0;
    logic [NREQ*2-1:0] req_mode = '0;
    logic [NREQ-1:0]   req_done;
    logic [NREQ-1:0]   req_err;
    logic              master_en;
    logic [DDW-1:0]    driver_data;
    logic [1:0]        driver_cfg;
    logic              driver_read = 1'b0;
    logic [3:0]        ss_n = 4'hF;
    logic              busy;
    logic [1:0]        grant_id;
    logic [1:0]        fsm_state;

    spi_req_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_ss(req_ss), .req_data(req_data), .req_addr(req_addr),
        .req_size(req_size), .req_write(req_write), .req_mode(req_mode),
        .req_done(req_done), .req_err(req_err),
        .master_en(master_en), .driver_data(driver_data), .driver_cfg(driver_cfg),
        .driver_read(driver_read), .ss_n(ss_n),
        .busy(busy), .grant_id(grant_id), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [1:0]  ss;
        logic [1:0]  size;
        logic        write;
        logic [31:0] data;
        logic [7:0]  addr;
        logic [1:0]  mode;
        int          w_rr;
        int          w_prio;
    } vec_t;

    vec_t vecs[7];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] oh(input int w);
        logic [3:0] one;
        one = 4'b0001;
        return one << w;
    endfunction

    // Requester i carries the vector payload offset by i so the winner is identifiable.
    task automatic set_payload(input vec_t v);
        for (int i = 0; i < NREQ; i++) begin
            req_ss[2*i +: 2]     = v.ss + 2'(i);
            req_data[DW*i +: DW] = v.data + 32'(i);
            req_addr[AW*i +: AW] = v.addr + 8'(i);
            req_size[2*i +: 2]   = v.size;
            req_write[i]         = v.write;
            req_mode[2*i +: 2]   = v.mode ^ 2'(i);
        end
    endtask

    function automatic logic [DDW-1:0] exp_dd(input vec_t v, input int w);
        logic [1:0]  s;
        logic [31:0] d;
        logic [7:0]  a;
        s = v.ss + 2'(w);
        d = v.data + 32'(w);
        a = v.addr + 8'(w);
        return {s, d, a, v.size, v.write};
    endfunction

    function automatic int exp_win(input vec_t v);
`ifdef SPI_ARB_PRIO0_EN
        return v.w_prio;
`else
        return v.w_rr;
`endif
    endfunction

    // Entered #1 after the accepting edge (ISSUE); leaves #1 after the edge back into IDLE.
    task automatic xfer(input int w, input logic [DDW-1:0] dd, input logic [1:0] cfg);
        check("issue_en", 64'(master_en), 64'd1);
        check("issue_busy", 64'(busy), 64'd1);
        check("issue_data", 64'(driver_data), 64'(dd));
        check("issue_cfg", 64'(driver_cfg), 64'(cfg));
        check("issue_gid", 64'(grant_id), 64'(w));
        driver_read = 1'b1;
        @(posedge clk);
        #1;
        driver_read = 1'b0;
        ss_n = 4'hE;
        #1;
        check("busy_en", 64'(master_en), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("busy_no_done", 64'(req_done), 64'd0);
        ss_n = 4'hF;
        #1;
        check("park_en", 64'(master_en), 64'd0);
        @(posedge clk);
        #1;
        check("done_pulse", 64'(req_done), 64'(oh(w)));
        check("done_en", 64'(master_en), 64'd0);
        check("done_data", 64'(driver_data), 64'(dd));
        @(posedge clk);
        #1;
        check("idle_done", 64'(req_done), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int w;
        int order[5];
        vec_t v;

        //          valid    ss    size  wr    data          addr   mode  rr prio
        vecs[0] = '{4'b0001, 2'd2, 2'd0, 1'b1, 32'h1234_5678, 8'h40, 2'd1, 0, 0};
        vecs[1] = '{4'b0100, 2'd1, 2'd3, 1'b1, 32'hDEAD_BEEF, 8'h10, 2'd0, 2, 2};
        vecs[2] = '{4'b1001, 2'd0, 2'd1, 1'b0, 32'h0000_00F0, 8'h22, 2'd2, 3, 0};
        vecs[3] = '{4'b1001, 2'd3, 2'd2, 1'b1, 32'hCAFE_0000, 8'h7F, 2'd3, 0, 0};
        vecs[4] = '{4'b0110, 2'd1, 2'd0, 1'b0, 32'h5555_AAAA, 8'h01, 2'd0, 1, 1};
        vecs[5] = '{4'b0011, 2'd2, 2'd1, 1'b1, 32'h0F0F_0F0F, 8'hC3, 2'd1, 0, 0};
        vecs[6] = '{4'b1000, 2'd0, 2'd2, 1'b0, 32'h8000_0001, 8'hFE, 2'd2, 3, 3};

        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 64'(fsm_state), 64'd0);
        check("rst_en", 64'(master_en), 64'd0);
        check("rst_data", 64'(driver_data), 64'd0);
        check("rst_cfg", 64'(driver_cfg), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_outs", 64'({req_ready, req_done, req_err}), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 7; k++) begin
            w = exp_win(vecs[k]);
            set_payload(vecs[k]);
            req_valid = vecs[k].valid;
            #1;
            check($sformatf("v%0d_ready", k), 64'(req_ready), 64'(oh(w)));
            @(posedge clk);
            #1;
            req_valid = '0;
            if (vecs[k].size == 2'd3) begin
                check($sformatf("v%0d_err", k), 64'(req_err), 64'(oh(w)));
                check($sformatf("v%0d_err_en", k), 64'(master_en), 64'd0);
                check($sformatf("v%0d_err_busy", k), 64'(busy), 64'd0);
                @(posedge clk);
                #1;
                check($sformatf("v%0d_err_clr", k), 64'(req_err), 64'd0);
                check($sformatf("v%0d_err_en2", k), 64'(master_en), 64'd0);
            end else begin
                xfer(w, exp_dd(vecs[k], w), vecs[k].mode ^ 2'(w));
            end
        end

        // All four held: round robin 0,1,2,3,0 (priority build: always 0).
`ifdef SPI_ARB_PRIO0_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        v = '{4'b1111, 2'd1, 2'd1, 1'b1, 32'hA5A5_0000, 8'h33, 2'd0, 0, 0};
        set_payload(v);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("rr%0d_ready", k), 64'(req_ready), 64'(oh(order[k])));
            @(posedge clk);
            #1;
            xfer(order[k], exp_dd(v, order[k]), v.mode ^ 2'(order[k]));
        end
        req_valid = '0;

        // ISSUE stall: driver_read withheld for 10 cycles.
        v = '{4'b0010, 2'd3, 2'd2, 1'b0, 32'h0BAD_F00D, 8'h5A, 2'd3, 1, 1};
        set_payload(v);
        req_valid = v.valid;
        #1;
        check("stall_ready", 64'(req_ready), 64'(oh(1)));
        @(posedge clk);
        #1;
        req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            check("stall_en", 64'(master_en), 64'd1);
            check("stall_data", 64'(driver_data), 64'(exp_dd(v, 1)));
            check("stall_done", 64'(req_done), 64'd0);
            @(posedge clk);
            #1;
        end
        xfer(1, exp_dd(v, 1), v.mode ^ 2'd1);

        // Reset in the middle of BUSY with a request still pending.
        v = '{4'b0100, 2'd0, 2'd0, 1'b1, 32'h1111_2222, 8'h08, 2'd1, 2, 2};
        set_payload(v);
        req_valid = v.valid;
        @(posedge clk);
        #1;
        driver_read = 1'b1;
        @(posedge clk);
        #1;
        driver_read = 1'b0;
        ss_n = 4'hE;
        #1;
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_en", 64'(master_en), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_outs", 64'({req_ready, req_done, req_err}), 64'd0);
        check("mid_rst_gid", 64'(grant_id), 64'd0);
        @(posedge clk);
        #1;
        check("mid_rst_en2", 64'(master_en), 64'd0);
        check("mid_rst_data", 64'(driver_data), 64'd0);
        ss_n = 4'hF;
        rst = 1'b0;
        req_valid = 4'b1100;
        #1;
        check("post_rst_ptr", 64'(req_ready), 64'(oh(2)));
        @(posedge clk);
        #1;
        req_valid = '0;
        xfer(2, exp_dd(v, 2), v.mode ^ 2'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
